// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and alignment check for the data-memory access stage
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } mem_size_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } mau_state_t;

    localparam int CNT_W = 4;

    function automatic logic is_misaligned(input mem_size_t size, input logic [2:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return |off[1:0];
            default: return |off;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane extract/extend for loads and lane merge for sub-word stores
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [63:0] rbuf,
    input  logic [63:0] wdata,
    input  logic [2:0]  offset,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [63:0] rdata,
    output logic [63:0] wdata64
);

    logic [5:0]  shamt;
    logic [63:0] lane;
    logic [63:0] mask;

    assign shamt = {offset, 3'b000};
    assign lane  = rbuf >> shamt;

    always_comb begin
        rdata = rbuf;
        mask  = '1;
        case (size)
            SZ_B: begin
                mask  = 64'h0000_0000_0000_00FF;
                rdata = is_unsigned ? {56'd0, lane[7:0]} : {{56{lane[7]}}, lane[7:0]};
            end
            SZ_H: begin
                mask  = 64'h0000_0000_0000_FFFF;
                rdata = is_unsigned ? {48'd0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
            end
            SZ_W: begin
                mask  = 64'h0000_0000_FFFF_FFFF;
                rdata = is_unsigned ? {32'd0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
            end
            default: begin
                mask  = '1;
                rdata = rbuf;
            end
        endcase
    end

    // Dword accesses are always at offset 0, so the full mask degenerates to a pass-through.
    assign wdata64 = (rbuf & ~(mask << shamt)) | ((wdata & mask) << shamt);

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - multicycle load/store stage with read-modify-write sub-word stores
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int ADDR_W   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    output logic              rsp_valid,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_misaligned
);

    mau_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       rbuf_q, rbuf_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [63:0]       rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    mem_size_t         size_q, size_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic              mis_q, mis_d;

    logic              req_mis;
    logic [63:0]       ext_rdata;
    logic [63:0]       merge_wdata;

    assign req_mis = is_misaligned(mem_size_t'(req_size), req_addr[2:0]);

    // Fed with rbuf_d so the load result is ready on the same edge that captures mem_rdata.
    mem_lane_align u_lane_align (
        .rbuf        (rbuf_d),
        .wdata       (wdata_q),
        .offset      (addr_q[2:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rdata       (ext_rdata),
        .wdata64     (merge_wdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rbuf_d      = rbuf_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        addr_d      = addr_q;
        size_d      = size_q;
        we_d        = we_q;
        uns_d       = uns_q;
        mis_d       = mis_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = mem_size_t'(req_size);
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    mis_d   = req_mis;
                    if (req_mis) begin
                        state_d     = RESP;
                        rsp_rdata_d = '0;
                    end else if (req_we && (mem_size_t'(req_size) == SZ_D)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                cnt_d   = CNT_W'(READ_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q <= CNT_W'(1)) begin
                    rbuf_d = mem_rdata;
                    if (we_q) begin
                        state_d = WRITE;
                    end else begin
                        state_d     = RESP;
                        rsp_rdata_d = ext_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WRITE: begin
                state_d     = RESP;
                rsp_rdata_d = '0;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rbuf_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            size_q      <= SZ_B;
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rbuf_q      <= rbuf_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            we_q        <= we_d;
            uns_q       <= uns_d;
            mis_q       <= mis_d;
        end
    end

    assign req_ready      = (state_q == IDLE);
    assign mem_rd         = (state_q == READ);
    assign mem_wr         = (state_q == WRITE);
    assign mem_wdata      = mem_wr ? merge_wdata : '0;
    assign mem_addr       = (state_q == IDLE) ? '0 : {addr_q[ADDR_W-1:3], 3'b000};
    assign rsp_valid      = (state_q == RESP);
    assign rsp_misaligned = (state_q == RESP) && mis_q;
    assign rsp_rdata      = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - two-latency bench for mem_access_unit against a byte-array memory model
module tb_mem_access_unit;

    localparam int          LAT0 = 1;
    localparam int          LAT1 = 3;
    localparam logic [63:0] JUNK = 64'hA5A5_5A5A_C3C3_3C3C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic [1:0]        req_ready, mem_rd, mem_wr, rsp_valid, rsp_misaligned;
    logic [1:0][63:0]  mem_addr, mem_wdata, rsp_rdata, mem_rdata;

    genvar g;
    for (g = 0; g < 2; g++) begin : g_dut
        mem_access_unit #(.READ_LAT(g == 0 ? LAT0 : LAT1), .ADDR_W(64)) u_dut (
            .clk            (clk),
            .reset          (reset),
            .req_valid      (req_valid),
            .req_ready      (req_ready[g]),
            .req_we         (req_we),
            .req_size       (req_size),
            .req_unsigned   (req_unsigned),
            .req_addr       (req_addr),
            .req_wdata      (req_wdata),
            .mem_addr       (mem_addr[g]),
            .mem_rd         (mem_rd[g]),
            .mem_wr         (mem_wr[g]),
            .mem_wdata      (mem_wdata[g]),
            .mem_rdata      (mem_rdata[g]),
            .rsp_valid      (rsp_valid[g]),
            .rsp_rdata      (rsp_rdata[g]),
            .rsp_misaligned (rsp_misaligned[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [63:0] init_val(input int j);
        logic [31:0] a, b;
        if (j == 32) return 64'h0011_2233_8055_6677;
        a = 32'(j) * 32'h9E37_79B9;
        b = ~(32'(j) * 32'h85EB_CA6B);
        return {a, b};
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memories: data is only valid in the single cycle READ_LAT after mem_rd.
    logic [63:0] ram [2][256];
    logic        ram_loaded = 1'b0;
    int          rcnt [2] = '{0, 0};
    logic [7:0]  raddr [2];

    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int j = 0; j < 256; j++) begin
                ram[0][j] <= init_val(j);
                ram[1][j] <= init_val(j);
            end
            ram_loaded <= 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            if (mem_rd[i]) begin
                rcnt[i]  <= lat_of(i);
                raddr[i] <= mem_addr[i][10:3];
            end else if (rcnt[i] != 0) begin
                rcnt[i] <= rcnt[i] - 1;
            end
            if (mem_wr[i] && ram_loaded) ram[i][mem_addr[i][10:3]] <= mem_wdata[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) mem_rdata[i] = (rcnt[i] == 1) ? ram[i][raddr[i]] : JUNK;
    end

    int          n_rd [2]   = '{0, 0};
    int          n_wr [2]   = '{0, 0};
    int          n_rsp [2]  = '{0, 0};
    int          wr_cyc [2] = '{0, 0};
    int          rsp_cyc [2] = '{0, 0};
    logic [63:0] wr_data [2];
    logic [63:0] rsp_data [2];
    logic        rsp_mis [2];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_rd[i]) n_rd[i] <= n_rd[i] + 1;
            if (mem_wr[i]) begin
                n_wr[i]    <= n_wr[i] + 1;
                wr_cyc[i]  <= cyc;
                wr_data[i] <= mem_wdata[i];
            end
            if (rsp_valid[i]) begin
                n_rsp[i]    <= n_rsp[i] + 1;
                rsp_cyc[i]  <= cyc;
                rsp_data[i] <= rsp_rdata[i];
                rsp_mis[i]  <= rsp_misaligned[i];
            end
        end
    end

    logic [7:0] ref_mem [2048];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_idle(input string name);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.u%0d.req_ready", name, i), 64'(req_ready[i]), 64'd1);
            check($sformatf("%s.u%0d.mem_rd", name, i), 64'(mem_rd[i]), 64'd0);
            check($sformatf("%s.u%0d.mem_wr", name, i), 64'(mem_wr[i]), 64'd0);
            check($sformatf("%s.u%0d.mem_addr", name, i), mem_addr[i], 64'd0);
            check($sformatf("%s.u%0d.mem_wdata", name, i), mem_wdata[i], 64'd0);
            check($sformatf("%s.u%0d.rsp_valid", name, i), 64'(rsp_valid[i]), 64'd0);
            check($sformatf("%s.u%0d.rsp_rdata", name, i), rsp_rdata[i], 64'd0);
            check($sformatf("%s.u%0d.rsp_mis", name, i), 64'(rsp_misaligned[i]), 64'd0);
        end
    endtask

    task automatic run_req(input string name, input logic we, input logic [1:0] size, input logic uns,
                           input logic [63:0] addr, input logic [63:0] wd);
        int          nb, t, lat, ersp, ewr, enrd, enwr;
        int          rd0 [2], wr0 [2], rsp0 [2];
        logic [63:0] exp_rd, exp_dw;
        logic        exp_mis;
        bit          done;
        nb      = 1 << size;
        exp_mis = (addr % 64'(nb)) != 0;
        exp_rd  = '0;
        exp_dw  = '0;
        if (!exp_mis && we) begin
            for (int b = 0; b < nb; b++) ref_mem[addr[10:0] + 11'(b)] = wd[8*b +: 8];
            for (int b = 0; b < 8; b++) exp_dw[8*b +: 8] = ref_mem[{addr[10:3], 3'b000} + 11'(b)];
        end else if (!exp_mis) begin
            for (int b = 0; b < nb; b++) exp_rd[8*b +: 8] = ref_mem[addr[10:0] + 11'(b)];
            if (!uns && nb < 8 && exp_rd[8*nb-1]) exp_rd = exp_rd | ~((64'd1 << (8*nb)) - 64'd1);
        end
        for (int i = 0; i < 2; i++) begin
            rd0[i]  = n_rd[i];
            wr0[i]  = n_wr[i];
            rsp0[i] = n_rsp[i];
            check($sformatf("%s.u%0d.ready", name, i), 64'(req_ready[i]), 64'd1);
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        t            = cyc;
        @(posedge clk); #1;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = {$urandom, $urandom};
        req_wdata    = {$urandom, $urandom};
        @(posedge clk); #1;
        req_valid = 1'b0;
        done      = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (n_rsp[0] != rsp0[0] && n_rsp[1] != rsp0[1]) done = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check($sformatf("%s.rsp_seen", name), 64'(done), 64'd1);
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < 2; i++) begin
            lat = lat_of(i);
            ewr = 0;
            if (exp_mis)            begin ersp = t + 1;       enrd = 0; enwr = 0; end
            else if (!we)           begin ersp = t + lat + 2; enrd = 1; enwr = 0; end
            else if (size == 2'd3)  begin ewr = t + 1;  ersp = t + 2;       enrd = 0; enwr = 1; end
            else                    begin ewr = t + lat + 2; ersp = t + lat + 3; enrd = 1; enwr = 1; end
            check($sformatf("%s.u%0d.rsp_count", name, i), 64'(n_rsp[i] - rsp0[i]), 64'd1);
            check($sformatf("%s.u%0d.rsp_cycle", name, i), 64'(rsp_cyc[i]), 64'(ersp));
            check($sformatf("%s.u%0d.rsp_mis", name, i), 64'(rsp_mis[i]), 64'(exp_mis));
            check($sformatf("%s.u%0d.rsp_rdata", name, i), rsp_data[i], exp_rd);
            check($sformatf("%s.u%0d.rdata_hold", name, i), rsp_rdata[i], exp_rd);
            check($sformatf("%s.u%0d.rd_count", name, i), 64'(n_rd[i] - rd0[i]), 64'(enrd));
            check($sformatf("%s.u%0d.wr_count", name, i), 64'(n_wr[i] - wr0[i]), 64'(enwr));
            if (enwr == 1) begin
                check($sformatf("%s.u%0d.wr_cycle", name, i), 64'(wr_cyc[i]), 64'(ewr));
                check($sformatf("%s.u%0d.wr_data", name, i), wr_data[i], exp_dw);
            end
        end
    endtask

    int          wr_snap [2];
    logic [1:0]  r_sz;
    logic [63:0] r_addr;

    initial begin
        for (int j = 0; j < 256; j++)
            for (int b = 0; b < 8; b++) ref_mem[j*8 + b] = init_val(j) >> (8*b);
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        reset = 1'b1;
        @(posedge clk); #1;

        run_req("lb_105",  1'b0, 2'd0, 1'b0, 64'h105, 64'd0);
        run_req("lbu_105", 1'b0, 2'd0, 1'b1, 64'h105, 64'd0);
        run_req("lb_103",  1'b0, 2'd0, 1'b0, 64'h103, 64'd0);
        run_req("lbu_103", 1'b0, 2'd0, 1'b1, 64'h103, 64'd0);
        run_req("lw_104",  1'b0, 2'd2, 1'b0, 64'h104, 64'd0);
        run_req("lh_104",  1'b0, 2'd1, 1'b0, 64'h104, 64'd0);
        run_req("lh_102",  1'b0, 2'd1, 1'b0, 64'h102, 64'd0);
        run_req("sd_100",  1'b1, 2'd3, 1'b0, 64'h100, 64'h1111_2222_3333_4444);
        run_req("sh_102",  1'b1, 2'd1, 1'b0, 64'h102, 64'h0000_0000_0000_BEEF);
        run_req("sd_108",  1'b1, 2'd3, 1'b0, 64'h108, 64'hDEAD_BEEF_0123_4567);
        run_req("ld_108",  1'b0, 2'd3, 1'b0, 64'h108, 64'd0);
        run_req("lw_102",  1'b0, 2'd2, 1'b0, 64'h102, 64'd0);
        run_req("sd_104",  1'b1, 2'd3, 1'b0, 64'h104, 64'h0123_4567_89AB_CDEF);
        run_req("sb_107",  1'b1, 2'd0, 1'b0, 64'h107, 64'h0000_0000_0000_00AA);
        run_req("ld_100",  1'b0, 2'd3, 1'b0, 64'h100, 64'd0);

        // Abort a sub-word store while both units sit in WAIT.
        for (int i = 0; i < 2; i++) wr_snap[i] = n_wr[i];
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 64'h107;
        req_wdata    = 64'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_idle("rst_wait");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
        for (int i = 0; i < 2; i++)
            check($sformatf("rst_wait.u%0d.no_wr", i), 64'(n_wr[i] - wr_snap[i]), 64'd0);
        run_req("lb_107",  1'b0, 2'd0, 1'b0, 64'h107, 64'd0);

        for (int n = 0; n < 40; n++) begin
            r_sz   = 2'($urandom_range(0, 3));
            r_addr = 64'($urandom_range(0, 2047));
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~((64'd1 << r_sz) - 64'd1);
            run_req($sformatf("rnd%0d", n), 1'($urandom_range(0, 1)), r_sz, 1'($urandom_range(0, 1)),
                    r_addr, {$urandom, $urandom});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
